// File: rtl/k_and_s_datapath_if.sv
// Decoded-instruction type and the control/status interface between the
// K&S control unit (master) and the datapath (slave).
package k_and_s_pkg;
    typedef enum logic [3:0] {
        I_NOP    = 4'd0,
        I_BRANCH = 4'd1,
        I_BZERO  = 4'd2,
        I_BNEG   = 4'd3,
        I_LOAD   = 4'd4,
        I_STORE  = 4'd5,
        I_MOVE   = 4'd6,
        I_ADD    = 4'd7,
        I_SUB    = 4'd8,
        I_AND    = 4'd9,
        I_OR     = 4'd10,
        I_HALT   = 4'd11
    } decoded_instruction_type;
endpackage

interface k_and_s_datapath_if;
    import k_and_s_pkg::*;

    logic                    branch;
    logic                    pc_enable;
    logic                    ir_enable;
    logic                    write_reg_enable;
    logic                    addr_sel;
    logic                    c_sel;
    logic [1:0]              operation;
    logic                    flags_reg_enable;
    decoded_instruction_type decoded_instruction;
    logic                    zero_op;
    logic                    neg_op;
    logic                    unsigned_overflow;
    logic                    signed_overflow;

    modport master (
        output branch, pc_enable, ir_enable, write_reg_enable,
               addr_sel, c_sel, operation, flags_reg_enable,
        input  decoded_instruction, zero_op, neg_op,
               unsigned_overflow, signed_overflow
    );

    modport slave (
        input  branch, pc_enable, ir_enable, write_reg_enable,
               addr_sel, c_sel, operation, flags_reg_enable,
        output decoded_instruction, zero_op, neg_op,
               unsigned_overflow, signed_overflow
    );
endinterface

// File: rtl/k_and_s_datapath.sv
// K&S multicycle processor datapath: PC, IR, 4x16 register file, ALU and
// flags register, driven by the control unit through k_and_s_datapath_if.
module k_and_s_datapath
    import k_and_s_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    k_and_s_datapath_if.slave   ctrl,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   data_out,
    input  logic [DATA_W-1:0]   data_in
);

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic [DATA_W-1:0] res;
        logic              carry;
        logic              ovf;
    } alu_out_t;

    logic [ADDR_W-1:0]       pc_r;
    logic [DATA_W-1:0]       ir_r;
    logic [DATA_W-1:0]       regs_r [4];
    logic                    zero_r;
    logic                    neg_r;
    logic                    uovf_r;
    logic                    sovf_r;

    logic [DATA_W-1:0]       a_s;
    logic [DATA_W-1:0]       b_s;
    alu_out_t                alu_s;
    logic [1:0]              wr_idx_s;
    logic [DATA_W-1:0]       wr_data_s;
    decoded_instruction_type dec_s;
    logic                    unused_s;

    // Sub uses a zero-extended difference so the top bit is the borrow (A<B).
    function automatic alu_out_t alu_f(input logic [1:0] op,
                                       input logic [DATA_W-1:0] a,
                                       input logic [DATA_W-1:0] b);
        alu_out_t       o;
        logic [DATA_W:0] ext;
        o.res   = {DATA_W{1'b0}};
        o.carry = 1'b0;
        o.ovf   = 1'b0;
        ext     = {(DATA_W+1){1'b0}};
        case (op)
            2'b00: begin
                ext     = {1'b0, a} + {1'b0, b};
                o.res   = ext[DATA_W-1:0];
                o.carry = ext[DATA_W];
                o.ovf   = (a[DATA_W-1] == b[DATA_W-1]) && (o.res[DATA_W-1] != a[DATA_W-1]);
            end
            2'b01: begin
                ext     = {1'b0, a} - {1'b0, b};
                o.res   = ext[DATA_W-1:0];
                o.carry = ext[DATA_W];
                o.ovf   = (a[DATA_W-1] != b[DATA_W-1]) && (o.res[DATA_W-1] != a[DATA_W-1]);
            end
            2'b10:   o.res = a & b;
            2'b11:   o.res = a | b;
            default: o.res = {DATA_W{1'b0}};
        endcase
        return o;
    endfunction

    // Instruction decode from the opcode byte; unknown codes fall back to NOP.
    always_comb begin
        dec_s = I_NOP;
        case (ir_r[15:8])
            8'h00:   dec_s = I_NOP;
            8'h01:   dec_s = I_BRANCH;
            8'h02:   dec_s = I_BZERO;
            8'h03:   dec_s = I_BNEG;
            8'h81:   dec_s = I_LOAD;
            8'h82:   dec_s = I_STORE;
            8'h91:   dec_s = I_MOVE;
            8'hA1:   dec_s = I_ADD;
            8'hA2:   dec_s = I_SUB;
            8'hA3:   dec_s = I_AND;
            8'hA4:   dec_s = I_OR;
            8'hFF:   dec_s = I_HALT;
            default: dec_s = I_NOP;
        endcase
    end

    // Operand read, ALU, register-write source/destination and RAM address mux.
    always_comb begin
        a_s   = regs_r[ir_r[3:2]];
        b_s   = regs_r[ir_r[1:0]];
        alu_s = alu_f(ctrl.operation, a_s, b_s);
        if (ctrl.c_sel) begin
            wr_idx_s  = ir_r[5:4];
            wr_data_s = alu_s.res;
        end else begin
            wr_idx_s  = ir_r[6:5];
            wr_data_s = data_in;
        end
        if (ctrl.addr_sel) begin
            ram_addr = ir_r[ADDR_W-1:0];
        end else begin
            ram_addr = pc_r;
        end
    end

    assign data_out                 = regs_r[ir_r[6:5]];
    assign ctrl.decoded_instruction = dec_s;
    assign ctrl.zero_op             = zero_r;
    assign ctrl.neg_op              = neg_r;
    assign ctrl.unsigned_overflow   = uovf_r;
    assign ctrl.signed_overflow     = sovf_r;
    assign unused_s                 = ir_r[7];

    // Program counter: branch target or increment, wrapping at 2^ADDR_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r <= {ADDR_W{1'b0}};
        end else if (ctrl.pc_enable) begin
            if (ctrl.branch) begin
                pc_r <= ir_r[ADDR_W-1:0];
            end else begin
                pc_r <= pc_r + PC_ONE;
            end
        end
    end

    // Instruction register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_r <= {DATA_W{1'b0}};
        end else if (ctrl.ir_enable) begin
            ir_r <= data_in;
        end
    end

    // Register file write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (ctrl.write_reg_enable) begin
            regs_r[wr_idx_s] <= wr_data_s;
        end
    end

    // Flags register, all four flags loaded together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_r <= 1'b0;
            neg_r  <= 1'b0;
            uovf_r <= 1'b0;
            sovf_r <= 1'b0;
        end else if (ctrl.flags_reg_enable) begin
            zero_r <= (alu_s.res == {DATA_W{1'b0}});
            neg_r  <= alu_s.res[DATA_W-1];
            uovf_r <= alu_s.carry;
            sovf_r <= alu_s.ovf;
        end
    end

endmodule

// File: tb/tb_k_and_s_datapath.sv
// Self-checking bench for k_and_s_datapath: behavioural model compared every
// cycle plus directed vectors with literal expectations.
module tb_k_and_s_datapath;
    import k_and_s_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  ram_addr;
    logic [15:0] data_out;
    logic [15:0] data_in;

    k_and_s_datapath_if cif();

    k_and_s_datapath #(.DATA_W(16), .ADDR_W(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ctrl     (cif.slave),
        .ram_addr (ram_addr),
        .data_out (data_out),
        .data_in  (data_in)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [4:0]  m_pc;
    logic [15:0] m_ir;
    logic [15:0] m_regs [4];
    logic        m_z, m_n, m_c, m_v;

    function automatic decoded_instruction_type exp_dec(input logic [7:0] opc);
        case (opc)
            8'h01: return I_BRANCH;
            8'h02: return I_BZERO;
            8'h03: return I_BNEG;
            8'h81: return I_LOAD;
            8'h82: return I_STORE;
            8'h91: return I_MOVE;
            8'hA1: return I_ADD;
            8'hA2: return I_SUB;
            8'hA3: return I_AND;
            8'hA4: return I_OR;
            8'hFF: return I_HALT;
            default: return I_NOP;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        int a, b, sa, sb, r, sr;
        logic [15:0] res;
        logic c, v;
        if (!rst_n) begin
            m_pc <= 5'd0;
            m_ir <= 16'd0;
            for (int i = 0; i < 4; i++) m_regs[i] <= 16'd0;
            m_z <= 1'b0; m_n <= 1'b0; m_c <= 1'b0; m_v <= 1'b0;
        end else begin
            a  = int'(m_regs[m_ir[3:2]]);
            b  = int'(m_regs[m_ir[1:0]]);
            sa = int'($signed(m_regs[m_ir[3:2]]));
            sb = int'($signed(m_regs[m_ir[1:0]]));
            c = 1'b0; v = 1'b0;
            case (cif.operation)
                2'b00: begin r = a + b; c = (r > 65535); sr = sa + sb; v = (sr > 32767) || (sr < -32768); end
                2'b01: begin r = a - b; c = (a < b);     sr = sa - sb; v = (sr > 32767) || (sr < -32768); end
                2'b10: r = a & b;
                default: r = a | b;
            endcase
            res = r[15:0];
            if (cif.flags_reg_enable) begin
                m_z <= (res == 16'd0); m_n <= res[15]; m_c <= c; m_v <= v;
            end
            if (cif.write_reg_enable) begin
                if (cif.c_sel) m_regs[m_ir[5:4]] <= res;
                else           m_regs[m_ir[6:5]] <= data_in;
            end
            if (cif.ir_enable) m_ir <= data_in;
            if (cif.pc_enable) m_pc <= cif.branch ? m_ir[4:0] : 5'((int'(m_pc) + 1) % 32);
        end
    end

    // Compare process: every falling edge outside reset.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("ram_addr", ram_addr, cif.addr_sel ? m_ir[4:0] : m_pc);
            chk("data_out", data_out, m_regs[m_ir[6:5]]);
            chk("decode", cif.decoded_instruction, exp_dec(m_ir[15:8]));
            chk("flags", {cif.zero_op, cif.neg_op, cif.unsigned_overflow, cif.signed_overflow},
                {m_z, m_n, m_c, m_v});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        cif.branch = 1'b0; cif.pc_enable = 1'b0; cif.ir_enable = 1'b0;
        cif.write_reg_enable = 1'b0; cif.addr_sel = 1'b0; cif.c_sel = 1'b0;
        cif.operation = 2'b00; cif.flags_reg_enable = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [15:0] w, input logic pe);
        data_in = w; cif.ir_enable = 1'b1; cif.pc_enable = pe;
        tick(); idle();
    endtask

    task automatic load_reg(input logic [1:0] r, input logic [15:0] val);
        fetch({8'h81, 1'b0, r, 5'd0}, 1'b0);
        data_in = val; cif.write_reg_enable = 1'b1; cif.c_sel = 1'b0;
        tick(); idle();
    endtask

    task automatic alu(input logic [7:0] opc, input logic [1:0] op,
                       input logic [1:0] d, input logic [1:0] a, input logic [1:0] b);
        fetch({opc, 2'b00, d, a, b}, 1'b0);
        cif.operation = op; cif.c_sel = 1'b1;
        cif.write_reg_enable = 1'b1; cif.flags_reg_enable = 1'b1;
        tick(); idle();
    endtask

    function automatic logic [3:0] flags_now();
        return {cif.zero_op, cif.neg_op, cif.unsigned_overflow, cif.signed_overflow};
    endfunction

    logic [7:0] opcodes [15];

    initial begin
        opcodes = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h81, 8'h82, 8'h91, 8'hA1,
                    8'hA2, 8'hA3, 8'hA4, 8'hFF, 8'h55, 8'h80, 8'hFE};
        idle();
        data_in = 16'hFFFF;
        cif.ir_enable = 1'b1;
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_ram_addr", ram_addr, 5'd0);
        chk("rst_decode", cif.decoded_instruction, I_NOP);
        chk("rst_flags", flags_now(), 4'b0000);
        chk("rst_data_out", data_out, 16'h0000);
        cif.ir_enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_decode", cif.decoded_instruction, I_NOP);

        // advance PC to 7, then fetch ADD r1=r2+r3 with PC increment
        cif.pc_enable = 1'b1;
        repeat (7) tick();
        idle();
        chk("pc7", ram_addr, 5'd7);
        fetch(16'hA11B, 1'b1);
        chk("fetch_decode", cif.decoded_instruction, I_ADD);
        chk("fetch_pc8", ram_addr, 5'd8);

        // ADD signed overflow
        load_reg(2'd2, 16'h7FFF);
        load_reg(2'd3, 16'h0001);
        alu(8'hA1, 2'b00, 2'd1, 2'd2, 2'd3);
        chk("add_flags", flags_now(), 4'b0101);
        fetch(16'h8220, 1'b0);
        chk("add_r1", data_out, 16'h8000);

        // SUB zero, then borrow
        load_reg(2'd2, 16'h0005);
        load_reg(2'd3, 16'h0005);
        alu(8'hA2, 2'b01, 2'd1, 2'd2, 2'd3);
        chk("sub_zero_flags", flags_now(), 4'b1000);
        load_reg(2'd2, 16'h0000);
        load_reg(2'd3, 16'h0001);
        alu(8'hA2, 2'b01, 2'd1, 2'd2, 2'd3);
        chk("sub_borrow_flags", flags_now(), 4'b0110);
        fetch(16'h8220, 1'b0);
        chk("sub_r1", data_out, 16'hFFFF);

        // SUB signed overflow, ADD carry-to-zero
        load_reg(2'd2, 16'h8000);
        alu(8'hA2, 2'b01, 2'd1, 2'd2, 2'd3);
        chk("sub_sovf_flags", flags_now(), 4'b0001);
        load_reg(2'd2, 16'hFFFF);
        alu(8'hA1, 2'b00, 2'd1, 2'd2, 2'd3);
        chk("add_carry_flags", flags_now(), 4'b1010);

        // AND, MOVE (as OR), flags hold, same-cycle self-update
        load_reg(2'd2, 16'hF0F0);
        load_reg(2'd3, 16'h0FF0);
        alu(8'hA3, 2'b10, 2'd1, 2'd2, 2'd3);
        fetch(16'h8220, 1'b0);
        chk("and_r1", data_out, 16'h00F0);
        alu(8'h91, 2'b11, 2'd1, 2'd2, 2'd2);
        chk("move_flags", flags_now(), 4'b0100);
        fetch(16'h8220, 1'b0);
        chk("move_r1", data_out, 16'hF0F0);
        load_reg(2'd1, 16'h0000);
        chk("flags_hold", flags_now(), 4'b0100);
        alu(8'hA1, 2'b00, 2'd2, 2'd2, 2'd2);
        alu(8'hA1, 2'b00, 2'd2, 2'd2, 2'd3);

        // decode sweep including unknown codes
        foreach (opcodes[i]) fetch({opcodes[i], 8'h00}, 1'b0);
        chk("decode_unknown", cif.decoded_instruction, I_NOP);
        fetch(16'hFF00, 1'b0);
        chk("decode_halt", cif.decoded_instruction, I_HALT);

        // PC wrap, branch, branch ignored without pc_enable
        cif.pc_enable = 1'b1;
        repeat (23) tick();
        idle();
        chk("pc31", ram_addr, 5'd31);
        cif.pc_enable = 1'b1;
        tick(); idle();
        chk("pc_wrap", ram_addr, 5'd0);
        fetch(16'h0113, 1'b0);
        cif.branch = 1'b1; cif.pc_enable = 1'b1;
        tick(); idle();
        chk("branch_pc", ram_addr, 5'd19);
        cif.branch = 1'b1;
        tick(); idle();
        chk("branch_ignored", ram_addr, 5'd19);

        // LOAD r2 from address 5, STORE r2
        fetch(16'h8145, 1'b0);
        cif.addr_sel = 1'b1;
        #1;
        chk("load_addr", ram_addr, 5'd5);
        data_in = 16'hBEEF; cif.write_reg_enable = 1'b1; cif.c_sel = 1'b0;
        tick(); idle();
        fetch(16'h8245, 1'b0);
        chk("store_data", data_out, 16'hBEEF);
        chk("store_decode", cif.decoded_instruction, I_STORE);

        // asynchronous reset mid-cycle
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_addr", ram_addr, 5'd0);
        chk("async_rst_decode", cif.decoded_instruction, I_NOP);
        chk("async_rst_flags", flags_now(), 4'b0000);
        chk("async_rst_data", data_out, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
